// File: rtl/oneshot_ctrl_pkg.sv
// oneshot_ctrl_pkg: shared FSM state encoding and default widths for the
// one-shot stop controller.
// Latency: n/a (declarations only). Backpressure: n/a.
// Contents: state_t (IDLE/DEAD/GUARD, 2-bit), DEF_DT_W, DEF_GT_W, DEF_CNT_W.
package oneshot_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEAD  = 2'd1,
    GUARD = 2'd2
  } state_t;

  localparam int DEF_DT_W  = 8;
  localparam int DEF_GT_W  = 4;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/stop_down_cnt.sv
// stop_down_cnt: loadable down-counter with last (cnt==1) and zero flags.
// Latency: load/dec/clr take effect on the next rising edge; flags are combinational from cnt.
// Backpressure: none; dec is ignored once the count reaches zero.
// Ports: clk, rst (sync, active-high), clr (sync clear), load/load_val,
//        dec (decrement enable), cnt (current value), last, zero.
module stop_down_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         last,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign last = (cnt == W'(1));
  assign zero = (cnt == '0);

endmodule

// File: rtl/oneshot_stop_ctrl.sv
// oneshot_stop_ctrl: sequences the shared trig_stop line for the layer one-shot arrays.
// Latency: trig in cycle N -> trig_acc and trig_stop in cycle N+1; stop lasts max(dead_time,1) clocks,
// then a guard_time re-arm window. Backpressure: triggers outside IDLE are dropped, never queued.
// Ports: clk, rst (sync active-high), en, trig, inhibit, dead_time, guard_time -> trig_stop,
//        trig_acc, busy; stop_cnt/cnt_clr form the accepted-stop counter, built only when
//        ONESHOT_STOP_CNT_EN is defined (otherwise stop_cnt is tied to 0).
module oneshot_stop_ctrl
  import oneshot_ctrl_pkg::*;
#(
  parameter int DT_W  = DEF_DT_W,
  parameter int GT_W  = DEF_GT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             trig,
  input  logic             inhibit,
  input  logic [DT_W-1:0]  dead_time,
  input  logic [GT_W-1:0]  guard_time,
  output logic             trig_stop,
  output logic             trig_acc,
  output logic             busy,
  output logic [CNT_W-1:0] stop_cnt,
  input  logic             cnt_clr
);

  state_t state, state_nxt;
  logic   trig_stop_nxt, trig_acc_nxt;
  logic   cnt_abort, d_load, d_dec, g_load, g_dec;
  logic   d_last, g_last, g_zero;
  logic   d_unused_zero;
  logic [DT_W-1:0] dcnt;
  logic [GT_W-1:0] gcnt;
  logic [DT_W-1:0] dead_load;

  // A zero dead time still gives one stop cycle.
  assign dead_load = (dead_time == '0) ? DT_W'(1) : dead_time;

  // The guard counter is loaded at acceptance and simply holds during DEAD,
  // so it doubles as the latched guard_time.
  stop_down_cnt #(.W(DT_W)) u_dead_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_abort),
    .load     (d_load),
    .load_val (dead_load),
    .dec      (d_dec),
    .cnt      (dcnt),
    .last     (d_last),
    .zero     (d_unused_zero)
  );

  stop_down_cnt #(.W(GT_W)) u_guard_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_abort),
    .load     (g_load),
    .load_val (guard_time),
    .dec      (g_dec),
    .cnt      (gcnt),
    .last     (g_last),
    .zero     (g_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      trig_stop <= 1'b1;
      trig_acc  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      trig_stop <= trig_stop_nxt;
      trig_acc  <= trig_acc_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt     = state;
    trig_stop_nxt = inhibit | ~en;
    trig_acc_nxt  = 1'b0;
    cnt_abort     = 1'b0;
    d_load        = 1'b0;
    d_dec         = 1'b0;
    g_load        = 1'b0;
    g_dec         = 1'b0;
    if (!en) begin
      // Disable aborts any window from any state.
      state_nxt     = IDLE;
      cnt_abort     = 1'b1;
      trig_stop_nxt = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (trig && !inhibit) begin
            state_nxt     = DEAD;
            trig_acc_nxt  = 1'b1;
            trig_stop_nxt = 1'b1;
            d_load        = 1'b1;
            g_load        = 1'b1;
          end
        end
        DEAD: begin
          d_dec         = 1'b1;
          trig_stop_nxt = 1'b1;
          if (d_last) begin
            // Stop drops on the first cycle after the dead window.
            state_nxt     = g_zero ? IDLE : GUARD;
            trig_stop_nxt = inhibit;
          end
        end
        GUARD: begin
          g_dec = 1'b1;
          if (g_last) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt     = IDLE;
          trig_stop_nxt = 1'b1;
        end
      endcase
    end
  end

`ifdef ONESHOT_STOP_CNT_EN
  logic [CNT_W-1:0] stop_cnt_q;

  // Clear wins over a coincident increment; the count saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      stop_cnt_q <= '0;
    end else if (trig_acc && (stop_cnt_q != '1)) begin
      stop_cnt_q <= stop_cnt_q + CNT_W'(1);
    end
  end

  assign stop_cnt = stop_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign stop_cnt       = '0;
`endif

endmodule
